// File: rtl/obi_mem_slave.sv
// Single-port memory model on a req/gnt/valid bus with fixed response latency,
// bounded outstanding transactions, LFSR-driven grant stalls and error responses.
module obi_mem_slave #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned DEPTH_WORDS     = 16384,
  parameter logic [31:0] BASE_ADDR       = 32'h0,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          STALL_EN        = 1'b0,
  parameter logic [15:0] STALL_MASK      = 16'h0003,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              wr,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        be,
  output logic              gnt,
  output logic              valid,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned PW       = DATA_W + 2;
  localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + (33'(DEPTH_WORDS) << 2);

  logic [DATA_W-1:0] MEM [DEPTH_WORDS];

  logic [CNT_W-1:0]       r_count;
  logic [15:0]            r_lfsr;
  logic [LATENCY*PW-1:0]  r_pipe;

  logic                   w_stall;
  logic                   w_accept;
  logic                   w_in_range;
  logic                   w_retire;
  logic                   w_fb;
  logic [31:0]            w_off;
  logic [IDX_W-1:0]       w_idx;
  logic [DATA_W-1:0]      w_rd;
  logic [PW-1:0]          w_stage0;
  logic [LATENCY*PW-1:0]  w_pipe_nxt;
  logic [PW-1:0]          w_last;
  logic                   w_unused;

  // Grant, address decode and stage-0 payload
  always_comb begin
    w_stall    = STALL_EN && ((r_lfsr & STALL_MASK) == 16'h0);
    gnt        = req && (r_count < CNT_W'(MAX_OUTSTANDING)) && !w_stall;
    w_accept   = req && gnt;
    w_in_range = ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < END_ADDR);
    w_off      = addr - BASE_ADDR;
    w_idx      = w_off[IDX_W+1:2];
    w_rd       = (w_in_range && !wr) ? MEM[w_idx] : '0;
    w_stage0   = w_accept ? {1'b1, !w_in_range, w_rd} : '0;
    w_fb       = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  end

  assign w_unused = ^{w_off[1:0], w_off[31:IDX_W+2]};

  // A response leaves the outstanding count on the edge it reaches the output stage
  generate
    if (LATENCY == 1) begin : g_lat1
      assign w_pipe_nxt = w_stage0;
      assign w_retire   = w_accept;
    end else begin : g_latn
      assign w_pipe_nxt = {r_pipe[(LATENCY-1)*PW-1:0], w_stage0};
      assign w_retire   = r_pipe[(LATENCY-1)*PW-1];
    end
  endgenerate

  assign w_last = r_pipe[LATENCY*PW-1 -: PW];
  assign valid  = w_last[PW-1];
  assign err    = w_last[PW-2];
  assign rdata  = w_last[DATA_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_lfsr  <= LFSR_SEED;
      r_pipe  <= '0;
    end else begin
      if (STALL_EN) r_lfsr <= {w_fb, r_lfsr[15:1]};
      r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_retire);
      r_pipe  <= w_pipe_nxt;
    end
  end

  // Byte-enabled write port; contents are not reset
  always_ff @(posedge clk) begin
    if (w_accept && wr && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) MEM[w_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule
